// File: rtl/audipus_i2s_pkg.sv
// Shared constants, state encoding and slot helpers for the I2S transmit path.
package audipus_i2s_pkg;

    localparam int SAMPLE_W   = 24;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int FIFO_DEPTH = 4;

    localparam int CNT_W  = $clog2(FRAME_BITS);
    localparam int SLOT_W = $clog2(SLOT_BITS);
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Slot positions 1..SAMPLE_W carry sample bits; position 0 is the Philips one-bit delay.
    function automatic logic is_data_bit(input logic [CNT_W-1:0] cnt);
        return (cnt[SLOT_W-1:0] != '0) && (cnt[SLOT_W-1:0] <= SLOT_W'(SAMPLE_W));
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Small synchronous sample FIFO; push is accepted when full only if a pop happens that cycle.
module i2s_sample_fifo
    import audipus_i2s_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [SAMPLE_W-1:0] wdata,
    output logic [SAMPLE_W-1:0] rdata,
    output logic [LVL_W-1:0]    level,
    output logic                full,
    output logic                empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr, r_rptr;
    logic [LVL_W-1:0]    r_level;
    logic                w_push, w_pop;

    assign full   = (r_level == LVL_W'(FIFO_DEPTH));
    assign empty  = (r_level == '0);
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign rdata  = r_mem[r_rptr];
    assign level  = r_level;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: each buffered sample is sent in both the left and right slots.
// Define I2S_TX_UNDERRUN_CNT_EN to enable the saturating 16-bit underrun_count.
module i2s_tx_serializer
    import audipus_i2s_pkg::*;
#(
    parameter int BCLK_DIV = 8,
    parameter int PREFILL  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                run,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                frame_start,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                overflow,
    output logic                underrun,
    output logic [15:0]         underrun_count
);
    localparam int               DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    state_t              r_state, w_next_state;
    logic [DIV_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_cnt, w_new_cnt;
    logic                r_started;
    logic                r_bclk, r_lrclk, r_sdata;
    logic                r_frame_start, r_overflow, r_underrun;
    logic [SAMPLE_W-1:0] r_sample, r_shift, w_load;
    logic                w_tc, w_fall, w_rise, w_boundary;
    logic                w_frame, w_stop, w_underrun;
    logic                w_fifo_full, w_fifo_empty;
    logic [SAMPLE_W-1:0] w_fifo_rdata;
    logic [LVL_W-1:0]    w_fifo_level;

    i2s_sample_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (w_frame),
        .wdata (in_data),
        .rdata (w_fifo_rdata),
        .level (w_fifo_level),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (run && (w_fifo_level >= LVL_W'(PREFILL))) w_next_state = RUN;
            RUN:  if (w_stop) w_next_state = IDLE;
        endcase
    end

    // The first terminal count after entry acts as a fall so every BCLK period starts low.
    always_comb begin
        w_tc       = 1'b0;
        w_fall     = 1'b0;
        w_rise     = 1'b0;
        w_boundary = 1'b0;
        if (r_state == RUN) begin
            w_tc       = (r_div == DIV_TC);
            w_fall     = w_tc && (r_bclk || !r_started);
            w_rise     = w_tc && !w_fall;
            w_boundary = w_fall && (!r_started || (r_cnt == CNT_LAST));
        end
        w_stop     = w_boundary && !run;
        w_frame    = w_boundary && run;
        w_underrun = w_frame && w_fifo_empty;
    end

    assign w_new_cnt = r_started ? r_cnt + CNT_W'(1) : '0;
    assign w_load    = w_fifo_empty ? '0 : w_fifo_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div         <= '0;
            r_cnt         <= '0;
            r_started     <= 1'b0;
            r_bclk        <= 1'b0;
            r_lrclk       <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_overflow    <= 1'b0;
            r_underrun    <= 1'b0;
            r_sample      <= '0;
            r_shift       <= '0;
        end else begin
            r_overflow    <= in_valid && w_fifo_full && !w_frame;
            r_frame_start <= w_frame;
            r_underrun    <= w_underrun;
            if ((r_state == IDLE) || w_stop) begin
                r_div     <= '0;
                r_cnt     <= '0;
                r_started <= 1'b0;
                r_bclk    <= 1'b0;
                r_lrclk   <= 1'b0;
                r_sdata   <= 1'b0;
            end else begin
                r_div <= w_tc ? '0 : r_div + DIV_W'(1);
                if (w_rise) r_bclk <= 1'b1;
                if (w_fall) begin
                    r_bclk    <= 1'b0;
                    r_started <= 1'b1;
                    r_cnt     <= w_new_cnt;
                    r_lrclk   <= w_new_cnt[CNT_W-1];
                    // Right slot replays the held sample from a fresh shift-register copy.
                    if (w_new_cnt == '0) begin
                        r_sample <= w_load;
                        r_shift  <= w_load;
                        r_sdata  <= 1'b0;
                    end else if (w_new_cnt[SLOT_W-1:0] == '0) begin
                        r_shift  <= r_sample;
                        r_sdata  <= 1'b0;
                    end else if (is_data_bit(w_new_cnt)) begin
                        r_sdata  <= r_shift[SAMPLE_W-1];
                        r_shift  <= {r_shift[SAMPLE_W-2:0], 1'b0};
                    end else begin
                        r_sdata  <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] r_urun_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_urun_cnt <= '0;
        else if (w_underrun && (r_urun_cnt != 16'hFFFF))
            r_urun_cnt <= r_urun_cnt + 16'd1;
    end

    assign underrun_count = r_urun_cnt;
`else
    assign underrun_count = '0;
`endif

    assign i2s_bclk    = r_bclk;
    assign i2s_lrclk   = r_lrclk;
    assign i2s_sdata   = r_sdata;
    assign frame_start = r_frame_start;
    assign fifo_level  = w_fifo_level;
    assign overflow    = r_overflow;
    assign underrun    = r_underrun;

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Downstream of the sine test-tone generator: accepts 24-bit samples qualified by a one-cycle valid pulse, buffers them in a 4-entry FIFO and serializes each sample onto a Philips-format I2S link (BCLK, LRCLK, SDATA), duplicating it into the left and right slots. All logic runs on the system clock; BCLK is generated as a divided, registered output.

## Interface
- BCLK_DIV, 8: clk cycles per BCLK half-period (≥2); BCLK period = 2·BCLK_DIV clk.
- PREFILL, 2: FIFO level required before leaving IDLE (1..4).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  one-cycle sample strobe; no back-pressure.
- in_data  in  24  signed sample, captured when in_valid=1.
- run  in  1  enable; 0 forces IDLE at the next frame boundary.
- i2s_bclk  out  1  bit clock, registered.
- i2s_lrclk  out  1  word select, 0=left, 1=right, registered.
- i2s_sdata  out  1  serial data, MSB first, registered.
- frame_start  out  1  one-cycle pulse when a new frame (bit 0) begins.
- fifo_level  out  3  FIFO occupancy 0..4.
- overflow  out  1  one-cycle pulse: in_valid while full and no pop that cycle.
- underrun  out  1  one-cycle pulse: frame started with FIFO empty.
- underrun_count  out  16  see Configuration.

## Operation
- Reset: all outputs 0, FIFO empty, state IDLE, divider and bit counters 0.
- States: IDLE, RUN. IDLE -> RUN when run=1 and fifo_level ≥ PREFILL. RUN -> IDLE when run=0 at a frame boundary (bit counter wraps 63->0); frame in progress always completes.
- IDLE: bclk, lrclk, sdata held 0; divider held 0; FIFO still accepts pushes.
- Divider: counts 0..BCLK_DIV-1; at terminal count bclk toggles. "Fall event" = cycle where bclk toggles 1->0; first event in RUN is the first terminal count after entry, treated as a fall (bclk starts low).
- Bit counter (6 bits, 0..63) advances on every fall event, wraps 63->0.
- On fall event with new count = 0: pop FIFO into shift register, pulse frame_start; if FIFO empty load 0 and pulse underrun.
- lrclk = bitcount[5] updated on fall events (changes at counts 0 and 32, one BCLK ahead of MSB).
- sdata on fall events: counts 1..24 -> sample bits 23..0; counts 33..56 -> same sample bits 23..0; all other counts 0.
- FIFO: push when in_valid and (not full or pop same cycle). Push and pop same cycle when full: both occur, level unchanged. Push into empty FIFO same cycle as frame-boundary pop: pop sees empty (underrun), push stored, no bypass.
- reset mid-frame: immediate return to reset values, partial frame discarded.

## Timing
- in_valid -> fifo_level increments next cycle.
- Fall event cycle N: bclk, lrclk, sdata, frame_start all update at edge N+1 (same-cycle alignment; sdata stable across following BCLK rising edge).
- Frame = 64 BCLK = 128·BCLK_DIV clk (1024 clk at default).
- IDLE -> RUN: first bclk toggle BCLK_DIV cycles after entry.

## Configuration
- I2S_TX_UNDERRUN_CNT_EN defined: underrun_count is a 16-bit counter incremented per underrun pulse, saturating at 0xFFFF, cleared only by reset.
- Not defined: underrun_count tied to 0; underrun pulse unaffected.

## Structure
- Package audipus_i2s_pkg: SAMPLE_W=24, SLOT_BITS=32, FRAME_BITS=64, FIFO_DEPTH=4, state enum {IDLE, RUN}.
- Sub-module i2s_sample_fifo: 4x24 synchronous FIFO with push/pop/level/full/empty; top holds divider, bit counter, FSM, shift register.

## Test plan
- Reset, push 0x7FFFFF and 0x800000, run=1 -> RUN entered; frame 0 left/right slots carry 0x7FFFFF MSB at bit 1/33, frame 1 carries 0x800000; frame_start every 1024 clk.
- Push one sample then stop, run=1, PREFILL=1 -> second frame outputs all-zero sdata, underrun pulses once, underrun_count=1 (macro on) / 0 (macro off).
- Push 6 samples back-to-back in IDLE -> fifo_level=4, overflow pulses on pushes 5 and 6.
- Full FIFO, in_valid coincident with frame-boundary pop -> no overflow, fifo_level stays 4.
- run deasserted at bit 20 -> frame completes to bit 63, then bclk/lrclk/sdata held 0, frame_start stops.
- Assert reset at bit 40 of a frame -> next cycle all outputs 0, fifo_level=0, state IDLE.
